// File: rtl/mpsub32_if.sv
// rtl/mpsub32_if.sv - operand/result handshake bundle for the word-serial subtractor
interface mpsub32_if #(
  parameter int WIDTH = 256
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             write;
  logic             start;
  logic [WIDTH:0]   d_out;
  logic             ready;

  // Requester side: supplies operands and commands, observes the result
  modport master (
    output a_in, b_in, write, start,
    input  d_out, ready
  );

  // Subtractor side
  modport slave (
    input  a_in, b_in, write, start,
    output d_out, ready
  );
endinterface

// File: rtl/mpsub32.sv
// rtl/mpsub32.sv - word-serial multi-precision subtractor, d = a - b, LSW first with borrow chain
module mpsub32 #(
  parameter int WIDTH = 256,
  parameter int WORD  = 32
) (
  input  logic       CLK,
  input  logic       RST,
  mpsub32_if.slave   bus
);
  localparam int NWORDS = WIDTH / WORD;
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg;
  // Holds the lower NWORDS-1 result words; the top word is merged straight into d_out
  logic [WIDTH-WORD-1:0] res;
  logic [WIDTH:0]    d_out_q;
  logic              ready_q;
  logic [CW-1:0]     cnt;
  logic              borrow;

  logic              load_op;
  logic              begin_run;
  logic              last_word;
  logic [WORD-1:0]   a_word, b_word;
  logic [WORD:0]     sub_w;

  assign bus.d_out = d_out_q;
  assign bus.ready = ready_q;

  // Current operand slices and the one-word subtract with incoming borrow
  always_comb begin
    a_word = a_reg[cnt*WORD +: WORD];
    b_word = b_reg[cnt*WORD +: WORD];
    sub_w  = {1'b0, a_word} - {1'b0, b_word} - {{WORD{1'b0}}, borrow};
  end

  // Next-state and control decode; write takes priority over start in IDLE
  always_comb begin
    state_next = state;
    load_op    = 1'b0;
    begin_run  = 1'b0;
    last_word  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.write) begin
          load_op = 1'b1;
        end else if (bus.start) begin
          begin_run  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(NWORDS - 1)) begin
          last_word  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Operand capture, borrow chain, result assembly and ready flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res     <= '0;
      d_out_q <= '0;
      ready_q <= 1'b0;
      cnt     <= '0;
      borrow  <= 1'b0;
    end else begin
      if (load_op) begin
        a_reg   <= bus.a_in;
        b_reg   <= bus.b_in;
        ready_q <= 1'b0;
      end
      if (begin_run) begin
        cnt     <= '0;
        borrow  <= 1'b0;
        ready_q <= 1'b0;
      end
      if (state == RUN) begin
        // Shift words in from the top so word 0 lands at the bottom after NWORDS-1 cycles
        res    <= {sub_w[WORD-1:0], res[WIDTH-WORD-1:WORD]};
        borrow <= sub_w[WORD];
        cnt    <= cnt + CW'(1);
        if (last_word) begin
          d_out_q <= {sub_w, res};
          ready_q <= 1'b1;
          cnt     <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mpsub32.sv
// tb/tb_mpsub32.sv - self-checking bench for mpsub32 against an arithmetic reference
module tb_mpsub32;
  localparam int W = 256;
  localparam logic [W-1:0] SEED =
    256'h6B17D1F2_E12C4247_F8BCE6E5_63A440F2_77037D81_2DEB33A0_F4A13945_D898C296;

  logic CLK;
  logic RST;
  int   vectors;
  int   miscompares;

  mpsub32_if #(.WIDTH(W)) bus ();

  mpsub32 #(.WIDTH(W), .WORD(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    for (int k = 0; k < W/32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.write = 1'b1;
    @(negedge CLK);
    bus.write = 1'b0;
  endtask

  task automatic do_start;
    @(negedge CLK);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  // Cycles from the start edge until ready is seen; -1 if it never rises
  task automatic wait_ready(output int lat);
    lat = 0;
    while (bus.ready !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    if (bus.ready !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 0", bus.ready);
    end
    vectors++;
    if (bus.d_out !== '0) begin
      miscompares++;
      $display("FAIL reset_dout: got %h expected 0", bus.d_out);
    end
    RST = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    logic [W:0] exp;
    exp = 257'h2;
    do_write(256'd5, 256'd3);
    do_start();
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_stale_ready: got %b expected 0", bus.ready);
    end
    wait_ready(lat);
    vectors++;
    if (lat != 8) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected 8", lat);
    end
    vectors++;
    if (bus.d_out !== exp) begin
      miscompares++;
      $display("FAIL basic_dout: got %h expected %h", bus.d_out, exp);
    end
    repeat (20) @(negedge CLK);
    vectors++;
    if (bus.ready !== 1'b1 || bus.d_out !== exp) begin
      miscompares++;
      $display("FAIL basic_hold: got ready=%b d=%h expected ready=1 d=%h", bus.ready, bus.d_out, exp);
    end
  endtask

  task automatic test_underflow;
    int lat;
    logic [W:0] exp;
    exp = {1'b1, {W{1'b1}}};
    do_write(256'd0, 256'd1);
    do_start();
    wait_ready(lat);
    vectors++;
    if (lat != 8 || bus.d_out !== exp) begin
      miscompares++;
      $display("FAIL underflow: got lat=%0d d=%h expected lat=8 d=%h", lat, bus.d_out, exp);
    end
  endtask

  task automatic test_cross_borrow;
    int lat;
    logic [W:0]   exp;
    logic [W-1:0] a;
    a   = 256'h1_00000000;
    exp = 257'hFFFFFFFF;
    do_write(a, 256'd1);
    do_start();
    wait_ready(lat);
    vectors++;
    if (lat != 8 || bus.d_out !== exp) begin
      miscompares++;
      $display("FAIL borrow_word1: got lat=%0d d=%h expected lat=8 d=%h", lat, bus.d_out, exp);
    end
    a   = 256'h1 << 224;
    exp = {1'b0, 32'h0, {7{32'hFFFFFFFF}}};
    do_write(a, 256'd1);
    do_start();
    wait_ready(lat);
    vectors++;
    if (lat != 8 || bus.d_out !== exp) begin
      miscompares++;
      $display("FAIL borrow_word7: got lat=%0d d=%h expected lat=8 d=%h", lat, bus.d_out, exp);
    end
  endtask

  task automatic test_equality;
    int lat;
    do_write(SEED, SEED);
    do_start();
    wait_ready(lat);
    vectors++;
    if (lat != 8 || bus.d_out !== '0) begin
      miscompares++;
      $display("FAIL equal_first: got lat=%0d d=%h expected lat=8 d=0", lat, bus.d_out);
    end
    do_start();
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL equal_restart_ready: got %b expected 0", bus.ready);
    end
    wait_ready(lat);
    vectors++;
    if (lat != 8 || bus.d_out !== '0) begin
      miscompares++;
      $display("FAIL equal_repeat: got lat=%0d d=%h expected lat=8 d=0", lat, bus.d_out);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int idle_bad;
    do_write(256'd5, 256'd3);
    do_start();
    wait_ready(lat);
    do_write(rand_op(), rand_op());
    do_start();
    repeat (4) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    vectors++;
    if (bus.ready !== 1'b0 || bus.d_out !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: got ready=%b d=%h expected ready=0 d=0", bus.ready, bus.d_out);
    end
    @(negedge CLK);
    RST = 1'b0;
    idle_bad = 0;
    repeat (12) begin
      @(negedge CLK);
      if (bus.ready !== 1'b0) idle_bad++;
    end
    vectors++;
    if (idle_bad != 0) begin
      miscompares++;
      $display("FAIL midrun_idle: got %0d ready cycles expected 0", idle_bad);
    end
    do_write(256'd9, 256'd4);
    do_start();
    wait_ready(lat);
    vectors++;
    if (lat != 8 || bus.d_out !== 257'd5) begin
      miscompares++;
      $display("FAIL midrun_after: got lat=%0d d=%h expected lat=8 d=5", lat, bus.d_out);
    end
  endtask

  task automatic test_write_start_same;
    int lat;
    int ready_seen;
    logic [W-1:0] a, b;
    a = rand_op();
    b = rand_op();
    @(negedge CLK);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.write = 1'b1;
    bus.start = 1'b1;
    @(negedge CLK);
    bus.write = 1'b0;
    bus.start = 1'b0;
    ready_seen = 0;
    repeat (10) begin
      if (bus.ready !== 1'b0) ready_seen++;
      @(negedge CLK);
    end
    vectors++;
    if (ready_seen != 0) begin
      miscompares++;
      $display("FAIL write_start_norun: got %0d ready cycles expected 0", ready_seen);
    end
    do_start();
    wait_ready(lat);
    vectors++;
    if (lat != 8 || bus.d_out !== ref_sub(a, b)) begin
      miscompares++;
      $display("FAIL write_start_latched: got lat=%0d d=%h expected lat=8 d=%h", lat, bus.d_out, ref_sub(a, b));
    end
  endtask

  task automatic test_ignore_during_run;
    int lat;
    logic [W-1:0] a, b;
    a = rand_op();
    b = rand_op();
    do_write(a, b);
    do_start();
    repeat (2) @(negedge CLK);
    bus.a_in  = rand_op();
    bus.b_in  = rand_op();
    bus.write = 1'b1;
    bus.start = 1'b1;
    @(negedge CLK);
    bus.write = 1'b0;
    bus.start = 1'b0;
    wait_ready(lat);
    vectors++;
    if (lat != 5 || bus.d_out !== ref_sub(a, b)) begin
      miscompares++;
      $display("FAIL ignore_run: got lat=%0d d=%h expected lat=5 d=%h", lat, bus.d_out, ref_sub(a, b));
    end
    do_start();
    wait_ready(lat);
    vectors++;
    if (lat != 8 || bus.d_out !== ref_sub(a, b)) begin
      miscompares++;
      $display("FAIL ignore_held: got lat=%0d d=%h expected lat=8 d=%h", lat, bus.d_out, ref_sub(a, b));
    end
  endtask

  task automatic test_random;
    int lat;
    logic [W-1:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = rand_op();
      case (i % 4)
        1:       b = a ^ {{(W-32){1'b0}}, $urandom()};
        2:       b = a;
        default: b = rand_op();
      endcase
      do_write(a, b);
      do_start();
      wait_ready(lat);
      vectors++;
      if (lat != 8 || bus.d_out !== ref_sub(a, b)) begin
        miscompares++;
        $display("FAIL random_%0d: got lat=%0d d=%h expected lat=8 d=%h", i, lat, bus.d_out, ref_sub(a, b));
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST         = 1'b1;
    bus.a_in    = '0;
    bus.b_in    = '0;
    bus.write   = 1'b0;
    bus.start   = 1'b0;
    test_reset();
    test_basic();
    test_underflow();
    test_cross_borrow();
    test_equality();
    test_reset_mid_run();
    test_write_start_same();
    test_ignore_during_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mpsub32.md
Name: mpsub32

Overview:
- Word-serial multi-precision subtractor; the inverse operation of the 32-bit-slice multi-precision adder.
- Computes d = a − b on 256-bit operands, one 32-bit word per cycle, LSW first, with a borrow chain.
- Uses the same write/start/ready operand handshake as the adder, so existing LFSR-driven benches drive it unchanged apart from the golden model.
- Sits beside the adder as the subtraction primitive for the modular-arithmetic datapath.

Parameters:
- WIDTH, 256, operand width in bits; must be a multiple of WORD.
- WORD, 32, slice width processed per cycle.
- NWORDS, WIDTH/WORD (8), derived; number of RUN cycles.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- a_in  input  WIDTH  minuend; sampled only on write.
- b_in  input  WIDTH  subtrahend; sampled only on write.
- write  input  1  load a_in/b_in into internal operand registers.
- start  input  1  begin subtraction of the held operands.
- d_out  output  WIDTH+1  bit WIDTH = final borrow (1 iff a<b); bits WIDTH-1:0 = (a−b) mod 2^WIDTH.
- ready  output  1  d_out valid; held high until the next write or start.

Behaviour:
- Clock and reset: one clock CLK; asynchronous, active-high reset RST.
- Reset: state=IDLE; ready=0; d_out=0; operand registers=0; word counter=0; borrow=0. An assertion mid-RUN aborts immediately; no partial result survives.
- States: IDLE, RUN.
- IDLE, write=1: latch a_in, b_in; ready<=0. If start is also 1 in the same cycle, write wins and start is ignored (no RUN).
- IDLE, start=1 and write=0: ready<=0; counter<=0; borrow<=0; go to RUN.
- RUN, each cycle k = 0..NWORDS-1:
  - {bout, diff} = {1'b0, a_word[k]} − {1'b0, b_word[k]} − borrow; WORD+1 bits, bout is the MSB.
  - Store diff into result word k; borrow<=bout; counter++.
- RUN, final word (k = NWORDS-1): d_out <= {bout, result}; ready<=1; go to IDLE.
- Latency: ready rises on the NWORDS-th rising edge after the edge that sampled start (8 cycles at defaults). ready is 0 on the edge that samples start, so a bench polling ready from that edge never sees a stale 1.
- write and start are ignored during RUN; the held operands are not disturbed.
- d_out is defined only while ready=1. Intermediate values while ready=0 are unspecified, except after reset, when d_out=0.
- ready stays 1 and d_out stays stable indefinitely in IDLE until the next accepted write or start.
- A start with no new write repeats the subtraction on the held operands and gives the identical result.
- Width rule: the result equals the low WIDTH+1 bits of {1'b0,a} − {1'b0,b}, so bit WIDTH is the borrow.

Test Plan:
1. Basic: a=5, b=3; write, then start -> ready 8 cycles after the start edge; d_out = 257'h0_..._00000002.
2. Underflow: a=0, b=1 -> d_out = {1'b1, 256'hFFFF...FFFF}, bit 256 = 1.
3. Cross-word borrow: a=256'h1_00000000, b=1 -> d_out = 257'h0_..._00000000_FFFFFFFF. Then a=2^224, b=1 -> words 0..6 = FFFFFFFF, word 7 = 0, borrow 0.
4. Equality: a=b=the 0x6B17D1F2… LFSR seed -> d_out=0; then start again with no write -> same result, ready again after 8 cycles.
5. Reset mid-RUN: assert RST at RUN cycle 4 -> ready=0 and d_out=0 immediately (asynchronously), state IDLE. After release, write a=9, b=4 and start -> d_out=5.
6. Handshake edges and randomised run:
   - write and start in the same cycle -> no RUN; ready stays 0 for 10 cycles.
   - start and write during RUN -> ignored; the result matches the original operands.
   - 1000 LFSR vector pairs compared against {1'b0,a} − {1'b0,b} -> zero mismatches.
